// File: rtl/gpio_pio_pkg.sv
// Shared constants for the GPIO PIO block: bus widths and the register word map.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gpio_pio_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// One switch channel: 2-flop synchroniser, then a stability filter when GPIO_DEBOUNCE_EN is defined.
// Latency: 2 clocks (filter off) or 2 + DB_CYCLES clocks (filter on) from pin to db.
// Backpressure: none; free-running per clock.
module gpio_debounce #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic db
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             db_q;

    // cnt holds the number of consecutive clocks sync2 has already disagreed with db_q;
    // the disagreeing clock that would make it DB_CYCLES commits the new level instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            db_q <= 1'b0;
        end else if (sync2 == db_q) begin
            cnt <= '0;
        end else if (cnt >= CNT_LAST) begin
            db_q <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign db = db_q;
`else
    assign db = sync2;
`endif

endmodule

// File: rtl/gpio_pio_ctrl.sv
// Memory-mapped GPIO: debounced switch inputs with edge capture/irq, LED outputs with set/clear.
// Latency: readdata 1 clock after read; led_export 1 clock after write; irq 1 clock after EDGE_CAP/IRQ_MASK.
// Backpressure: none; a write in the same cycle as a read wins and the read is dropped. GPIO_DEBOUNCE_EN enables filtering.
module gpio_pio_ctrl
    import gpio_pio_pkg::*;
#(
    parameter int               IN_W      = 8,
    parameter int               OUT_W     = 8,
    parameter logic [OUT_W-1:0] OUT_RESET = '0,
    parameter int               DB_CYCLES = 50000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    input  logic [IN_W-1:0]   switch_export,
    output logic [OUT_W-1:0]  led_export
);

    logic [IN_W-1:0]   db;
    logic [IN_W-1:0]   db_prev;
    logic [IN_W-1:0]   irq_mask;
    logic [IN_W-1:0]   edge_cap;
    logic [IN_W-1:0]   edge_cap_nxt;
    logic [IN_W-1:0]   edge_set;
    logic [IN_W-1:0]   edge_clr;
    logic [IN_W-1:0]   rise_en;
    logic [IN_W-1:0]   fall_en;
    logic [IN_W-1:0]   wd_in;
    logic [OUT_W-1:0]  wd_out;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdat;

    for (genvar i = 0; i < IN_W; i++) begin : g_ch
        gpio_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .pin   (switch_export[i]),
            .db    (db[i])
        );
    end

    assign wd_in       = writedata[IN_W-1:0];
    assign wd_out      = writedata[OUT_W-1:0];
    assign unused_wdat = ^writedata;

    // db_prev resets to 0, so inputs already high at release register as a rising edge.
    assign edge_set = (db & ~db_prev & rise_en) | (~db & db_prev & fall_en);
    assign edge_clr = (write && address == ADDR_EDGE_CAP) ? wd_in : '0;
    assign edge_cap_nxt = (edge_cap & ~edge_clr) | edge_set;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA_IN:  rd_mux[IN_W-1:0]  = db;
            ADDR_DATA_OUT: rd_mux[OUT_W-1:0] = led_export;
            ADDR_IRQ_MASK: rd_mux[IN_W-1:0]  = irq_mask;
            ADDR_EDGE_CAP: rd_mux[IN_W-1:0]  = edge_cap;
            ADDR_RISE_EN:  rd_mux[IN_W-1:0]  = rise_en;
            ADDR_FALL_EN:  rd_mux[IN_W-1:0]  = fall_en;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_export <= OUT_RESET;
            irq_mask   <= '0;
            edge_cap   <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            db_prev    <= '0;
            readdata   <= '0;
            irq        <= 1'b0;
        end else begin
            db_prev  <= db;
            edge_cap <= edge_cap_nxt;
            irq      <= |(edge_cap & irq_mask);
            if (write) begin
                case (address)
                    ADDR_DATA_OUT: led_export <= wd_out;
                    ADDR_IRQ_MASK: irq_mask   <= wd_in;
                    ADDR_OUT_SET:  led_export <= led_export | wd_out;
                    ADDR_OUT_CLR:  led_export <= led_export & ~wd_out;
                    ADDR_RISE_EN:  rise_en    <= wd_in;
                    ADDR_FALL_EN:  fall_en    <= wd_in;
                    default: ;
                endcase
            end else if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: doc/gpio_pio_ctrl.md
GPIO_PIO_CTRL -- requirements
Module: gpio_pio_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 8: switch input channel count, 1..32.
REQ-002 SHALL have parameter OUT_W, default 8: LED output channel count, 1..32.
REQ-003 SHALL have parameter OUT_RESET, default 0: led_export value at reset, OUT_W bits.
REQ-004 SHALL have parameter DB_CYCLES, default 50000: debounce stability window in clocks, 2..2^20.
REQ-005 SHALL have ports: clk_clk  in  1  sole clock.
REQ-006 SHALL have ports: reset_reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports: address  in  3  word address; read  in  1; write  in  1; writedata  in  32.
REQ-008 SHALL have ports: readdata  out  32  read data; irq  out  1  level interrupt.
REQ-009 SHALL have ports: switch_export  in  IN_W  asynchronous inputs; led_export  out  OUT_W  registered outputs.

Function
REQ-010 SHALL implement register map: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 IRQ_MASK (RW), 3 EDGE_CAP (R, W1C), 4 OUT_SET (WO), 5 OUT_CLR (WO), 6 RISE_EN (RW), 7 FALL_EN (RW).
REQ-011 SHALL pass each switch_export bit through a 2-flop synchroniser before any other use.
REQ-012 SHALL return readdata exactly 1 cycle after read is sampled high; upper unused bits and write-only addresses read 0.
REQ-013 SHALL hold readdata at its last value when read is low.
REQ-014 SHALL update led_export 1 cycle after a write: DATA_OUT loads, OUT_SET ORs, OUT_CLR AND-NOTs writedata[OUT_W-1:0].
REQ-015 SHALL set EDGE_CAP[i] on a 0->1 transition of debounced input i when RISE_EN[i]=1, and on 1->0 when FALL_EN[i]=1.
REQ-016 SHALL clear EDGE_CAP bits written with 1 at address 3; when set and clear coincide on one bit in the same cycle, set wins.
REQ-017 SHALL drive irq registered: irq = OR(EDGE_CAP & IRQ_MASK), 1 cycle after either operand changes.
REQ-018 SHALL ignore read and write asserted together; write takes priority, read data is not updated.

Reset
REQ-019 SHALL, while reset_reset_n is low, force: led_export=OUT_RESET, readdata=0, irq=0, IRQ_MASK=0, EDGE_CAP=0, RISE_EN=0, FALL_EN=0, synchronisers=0, debounced state=0, debounce counters=0.
REQ-020 SHALL treat inputs high after reset release as a rising edge once debounced (reported only if RISE_EN set).
REQ-021 SHALL abort any in-progress debounce count on reset assertion mid-window.

Configuration
REQ-022 SHALL, with GPIO_DEBOUNCE_EN defined, update debounced bit i only after synchronised input differs from it for DB_CYCLES consecutive clocks; any return to equality resets the counter to 0; counter saturates, never wraps.
REQ-023 SHALL, without GPIO_DEBOUNCE_EN, use synchronised input directly as debounced state (edge latency 3 clocks from pin), and DB_CYCLES is ignored with no counters instantiated.

Structure
REQ-024 SHALL place register address constants (ADDR_DATA_IN..ADDR_FALL_EN), data width 32 and address width 3 in shared package gpio_pio_pkg.
REQ-025 SHALL implement per-channel synchroniser plus debounce in sub-module gpio_debounce, instantiated IN_W times.
REQ-026 SHALL size the debounce counter as ceil(log2(DB_CYCLES+1)) bits.

Verification
REQ-027 SHALL cover: write 0xA5 to addr 1, then 0x0F to addr 4, then 0x81 to addr 5 -> led_export 0xA5, 0xAF, 0x2E, each 1 cycle after write.
REQ-028 SHALL cover (DB_CYCLES=16, debounce on): switch[2] high for 10 clocks then low -> DATA_IN[2] stays 0; high for 20 clocks -> DATA_IN[2]=1 after 16+2 clocks.
REQ-029 SHALL cover: RISE_EN=0x04, IRQ_MASK=0x04, switch[2] rises -> EDGE_CAP=0x04, irq=1; write 0x04 to addr 3 -> irq=0 after 2 clocks.
REQ-030 SHALL cover: W1C of EDGE_CAP[3] in same cycle as new falling edge on switch[3] with FALL_EN[3]=1 -> EDGE_CAP[3] remains 1.
REQ-031 SHALL cover: OUT_RESET=0x3C, assert reset_reset_n low mid-debounce with led_export=0xFF -> led_export=0x3C immediately, irq=0, readdata=0 of addr 3 after release.
